sys_bus_interconnect: RTL and testbench

SYS_BUS_INTERCONNECT -- requirements
Module: sys_bus_interconnect

---
 rtl/sys_bus_interconnect.sv | 153 +++++++++++++++
 tb/tb_sys_bus_interconnect.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_interconnect.sv
// Single-outstanding bridge from one upstream port to eight address-decoded
// regions (addr[22:20]), with per-region enable mask and ack timeout.
//
// state | meaning
// IDLE  | waiting for an upstream strobe; strobes are dropped while sys_ack_o is high
// BUSY  | downstream access outstanding; waiting for latched-region ack or timeout
module sys_bus_interconnect #(
  parameter int             DW        = 32,
  parameter int             AW        = 32,
  parameter int             SW        = DW/8,
  parameter int             NUM       = 8,
  parameter logic [NUM-1:0] REGION_EN = 8'hFF,
  parameter int             TO_CYC    = 32
) (
  input  logic              sys_clk_i,
  input  logic              sys_rstn_i,
  input  logic [AW-1:0]     sys_addr_i,
  input  logic [DW-1:0]     sys_wdata_i,
  input  logic [SW-1:0]     sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [DW-1:0]     sys_rdata_o,
  output logic              sys_err_o,
  output logic              sys_ack_o,
  output logic [AW-1:0]     sysn_addr_o,
  output logic [DW-1:0]     sysn_wdata_o,
  output logic [SW-1:0]     sysn_sel_o,
  output logic [NUM-1:0]    sysn_wen_o,
  output logic [NUM-1:0]    sysn_ren_o,
  input  logic [NUM*DW-1:0] sysn_rdata_i,
  input  logic [NUM-1:0]    sysn_err_i,
  input  logic [NUM-1:0]    sysn_ack_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Down-counter loaded on accept; reaching zero in BUSY marks BUSY cycle TO_CYC.
  localparam logic [7:0] TO_LOAD = 8'(TO_CYC - 1);

  state_t         state_q, state_d;
  logic [2:0]     region_q, region_d;
  logic           op_wr_q, op_wr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [NUM-1:0] wen_q, wen_d;
  logic [NUM-1:0] ren_q, ren_d;

  logic [2:0] req_region;
  logic       req_valid;

  assign req_region = sys_addr_i[22:20];
  assign req_valid  = (sys_wen_i | sys_ren_i) & ~ack_q;

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    op_wr_d  = op_wr_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    wen_d    = '0;
    ren_d    = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = sys_addr_i;
          wdata_d  = sys_wdata_i;
          sel_d    = sys_sel_i;
          op_wr_d  = sys_wen_i;
          region_d = req_region;
          cnt_d    = TO_LOAD;
          state_d  = BUSY;
          if (REGION_EN[req_region]) begin
            if (sys_wen_i) wen_d[req_region] = 1'b1;
            else           ren_d[req_region] = 1'b1;
          end
        end
      end
      BUSY: begin
        // Disabled regions never got a strobe; fail them after one BUSY cycle.
        if (!REGION_EN[region_q]) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sysn_ack_i[region_q]) begin
          ack_d   = 1'b1;
          err_d   = sysn_err_i[region_q];
          rdata_d = op_wr_q ? '0 : sysn_rdata_i[int'(region_q)*DW +: DW];
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q  <= IDLE;
      region_q <= '0;
      op_wr_q  <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      wen_q    <= '0;
      ren_q    <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      op_wr_q  <= op_wr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
    end
  end

  assign sys_rdata_o  = rdata_q;
  assign sys_err_o    = err_q;
  assign sys_ack_o    = ack_q;
  assign sysn_addr_o  = addr_q;
  assign sysn_wdata_o = wdata_q;
  assign sysn_sel_o   = sel_q;
  assign sysn_wen_o   = wen_q;
  assign sysn_ren_o   = ren_q;

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Scoreboard bench for sys_bus_interconnect: directed scenarios plus random
// traffic against a transaction-level model with a responding region model.
module tb_sys_bus_interconnect;
  localparam int         DW  = 32;
  localparam int         AW  = 32;
  localparam int         SW  = 4;
  localparam int         NUM = 8;
  localparam int         TO  = 32;
  localparam logic [7:0] EN  = 8'h7F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [AW-1:0]     sys_addr_i = '0;
  logic [DW-1:0]     sys_wdata_i = '0;
  logic [SW-1:0]     sys_sel_i = '0;
  logic              sys_wen_i = 1'b0;
  logic              sys_ren_i = 1'b0;
  logic [DW-1:0]     sys_rdata_o;
  logic              sys_err_o;
  logic              sys_ack_o;
  logic [AW-1:0]     sysn_addr_o;
  logic [DW-1:0]     sysn_wdata_o;
  logic [SW-1:0]     sysn_sel_o;
  logic [NUM-1:0]    sysn_wen_o;
  logic [NUM-1:0]    sysn_ren_o;
  logic [NUM*DW-1:0] sysn_rdata_i = '0;
  logic [NUM-1:0]    sysn_err_i = '0;
  logic [NUM-1:0]    sysn_ack_i = '0;

  sys_bus_interconnect #(
    .DW(DW), .AW(AW), .SW(SW), .NUM(NUM), .REGION_EN(EN), .TO_CYC(TO)
  ) dut (
    .sys_clk_i(clk), .sys_rstn_i(rst_n),
    .sys_addr_i(sys_addr_i), .sys_wdata_i(sys_wdata_i), .sys_sel_i(sys_sel_i),
    .sys_wen_i(sys_wen_i), .sys_ren_i(sys_ren_i),
    .sys_rdata_o(sys_rdata_o), .sys_err_o(sys_err_o), .sys_ack_o(sys_ack_o),
    .sysn_addr_o(sysn_addr_o), .sysn_wdata_o(sysn_wdata_o), .sysn_sel_o(sysn_sel_o),
    .sysn_wen_o(sysn_wen_o), .sysn_ren_o(sysn_ren_o),
    .sysn_rdata_i(sysn_rdata_i), .sysn_err_i(sysn_err_i), .sysn_ack_i(sysn_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int cyc; logic err; logic [31:0] rdata;} resp_t;
  typedef struct {int cyc; logic [7:0] wen; logic [7:0] ren;
                  logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel;} strb_t;
  typedef struct {int dly; logic [31:0] rdata; logic err; logic [2:0] region;} slv_t;

  resp_t resp_q[$];
  strb_t strb_q[$];
  slv_t  slv_q[$];

  int          pending = 0;
  int          slv_cnt = 0;
  slv_t        cur;
  int          noise_r;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // Downstream side: checks strobes against the scoreboard, then plays the region.
  always @(negedge clk) begin
    strb_t st;
    if (!rst_n) pending = 0;
    if (sysn_wen_o != '0 || sysn_ren_o != '0) begin
      if (strb_q.size() == 0) begin
        chk("unexpected_strobe", {sysn_wen_o, sysn_ren_o}, 64'h0);
      end else begin
        st = strb_q.pop_front();
        chk("strobe_cyc", cyc, st.cyc);
        chk("strobe_wen", sysn_wen_o, st.wen);
        chk("strobe_ren", sysn_ren_o, st.ren);
        chk("strobe_addr", sysn_addr_o, st.addr);
        chk("strobe_wdata", sysn_wdata_o, st.wdata);
        chk("strobe_sel", sysn_sel_o, st.sel);
        if (slv_q.size() > 0) begin
          cur = slv_q.pop_front();
          slv_cnt = cur.dly;
          pending = 1;
        end
      end
    end
    sysn_ack_i = '0;
    sysn_err_i = '0;
    for (int k = 0; k < NUM; k++) sysn_rdata_i[k*DW +: DW] = $urandom;
    if (pending != 0) begin
      if (slv_cnt == 0) begin
        sysn_ack_i[cur.region] = 1'b1;
        sysn_err_i[cur.region] = cur.err;
        sysn_rdata_i[int'(cur.region)*DW +: DW] = cur.rdata;
        pending = 0;
      end else begin
        slv_cnt = slv_cnt - 1;
        if ($urandom_range(0, 2) == 0) begin
          noise_r = (int'(cur.region) + 1 + int'($urandom_range(0, 6))) % 8;
          sysn_ack_i[noise_r] = 1'b1;
          sysn_err_i[noise_r] = 1'b1;
        end
      end
    end
  end

  // Upstream monitor: pops the expected response whenever sys_ack_o is seen.
  always @(negedge clk) begin
    resp_t r;
    if (!rst_n) begin
      last_err = 1'b0;
      last_rdata = '0;
    end
    if (sys_ack_o) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_ack", sys_ack_o, 64'h0);
      end else begin
        r = resp_q.pop_front();
        chk("ack_cyc", cyc, r.cyc);
        chk("ack_err", sys_err_o, r.err);
        chk("ack_rdata", sys_rdata_o, r.rdata);
        last_err = r.err;
        last_rdata = r.rdata;
      end
    end else begin
      chk("hold_err", sys_err_o, last_err);
      chk("hold_rdata", sys_rdata_o, last_rdata);
    end
  end

  // Called just after a negedge; the request is sampled at the next posedge.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic rd,
                       input logic [31:0] wdata, input logic [3:0] sel, input int dly,
                       input logic [31:0] rdata, input logic serr);
    int         c;
    logic [2:0] rg;
    logic [7:0] en_mask;
    logic [7:0] onehot;
    resp_t      r;
    strb_t      s;
    slv_t       v;
    en_mask = EN;
    sys_addr_i = addr; sys_wdata_i = wdata; sys_sel_i = sel;
    sys_wen_i = wr; sys_ren_i = rd;
    c = cyc;
    rg = addr[22:20];
    onehot = 8'(1 << rg);
    if (!en_mask[rg]) begin
      r = '{c + 2, 1'b1, 32'h0};
    end else begin
      s = '{c + 1, wr ? onehot : 8'h0, wr ? 8'h0 : onehot, addr, wdata, sel};
      strb_q.push_back(s);
      v = '{dly, rdata, serr, rg};
      slv_q.push_back(v);
      if (dly <= TO - 1) r = '{c + 2 + dly, serr, wr ? 32'h0 : rdata};
      else               r = '{c + TO + 1, 1'b1, 32'h0};
    end
    resp_q.push_back(r);
    @(negedge clk);
    sys_wen_i = 1'b0; sys_ren_i = 1'b0;
  endtask

  task automatic drop(input logic [31:0] addr, input logic wr, input logic rd);
    sys_addr_i = addr; sys_wdata_i = $urandom; sys_sel_i = 4'($urandom);
    sys_wen_i = wr; sys_ren_i = rd;
    @(negedge clk);
    sys_wen_i = 1'b0; sys_ren_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((resp_q.size() != 0 || strb_q.size() != 0 || pending != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=%0d_pending_responses required=0", resp_q.size());
      resp_q.delete(); strb_q.delete(); slv_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, sys_ack_o, 64'h0);
    chk({tag, "_err"}, sys_err_o, 64'h0);
    chk({tag, "_rdata"}, sys_rdata_o, 64'h0);
    chk({tag, "_wen"}, sysn_wen_o, 64'h0);
    chk({tag, "_ren"}, sysn_ren_o, 64'h0);
    chk({tag, "_addr"}, sysn_addr_o, 64'h0);
    chk({tag, "_wdata"}, sysn_wdata_o, 64'h0);
    chk({tag, "_sel"}, sysn_sel_o, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=no_finish required=finish_by_500000");
    $fatal(1);
  end

  initial begin
    int x;
    int pick;
    int dly;
    int op;
    logic [31:0] a;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(32'h0030_0004, 1'b0, 1'b1, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0);
    wait_idle();
    issue(32'h0010_0000, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hF, 1, 32'h5555_AAAA, 1'b0);
    wait_idle();
    issue(32'h0050_0000, 1'b0, 1'b1, 32'h0, 4'h3, 40, 32'hDEAD_BEEF, 1'b0);
    wait_idle();
    issue(32'h0060_0008, 1'b0, 1'b1, 32'h0, 4'hF, 31, 32'h0BAD_F00D, 1'b0);
    wait_idle();
    issue(32'h0040_000C, 1'b0, 1'b1, 32'h0, 4'hF, 32, 32'h7777_7777, 1'b0);
    wait_idle();
    issue(32'h0070_0000, 1'b1, 1'b0, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b0);
    wait_idle();

    issue(32'h0020_0010, 1'b0, 1'b1, 32'h0, 4'hF, 5, 32'hA5A5_0001, 1'b1);
    @(negedge clk);
    drop(32'h0020_0014, 1'b0, 1'b1);
    wait_idle();

    x = cyc + 5;
    issue(32'h0010_0020, 1'b0, 1'b1, 32'h0, 4'hF, 3, 32'h0000_BEEF, 1'b0);
    while (cyc < x) @(negedge clk);
    drop(32'h0030_0000, 1'b1, 1'b0);
    issue(32'h0000_0040, 1'b1, 1'b0, 32'h1357_9BDF, 4'h5, 0, 32'h0, 1'b0);
    wait_idle();

    issue(32'h0010_0010, 1'b0, 1'b1, 32'h0, 4'hF, 10, 32'hFACE_0000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_busy");
    resp_q.delete(); strb_q.delete(); slv_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'h0010_0010, 1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0F0F_F0F0, 1'b0);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 5)      dly = pick;
      else if (pick == 6) dly = 31;
      else if (pick == 7) dly = 32;
      else if (pick == 8) dly = 40;
      else                dly = $urandom_range(6, 20);
      op = $urandom_range(0, 2);
      a = $urandom;
      issue(a, op != 1, op != 0, $urandom, 4'($urandom), dly, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) drop($urandom, 1'($urandom), 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
